// File: rtl/lcd_scanout.sv
// LCD frame scanout engine.
// Walks the visible WIDTH x HEIGHT window of a page-organised framebuffer
// (8 pages of 132 bytes, one bit per line, 64 lines in total) and emits one
// pixel per transfer in raster order. Each pixel costs FETCH -> WAIT -> OUTPUT.
// The framebuffer is a synchronous-read memory: the address is presented
// during FETCH, and the data arrives during WAIT.
//
// Pixel handshake: a pixel transfers on every rising clock edge where
// pixel_valid and pixel_ready are both 1. While pixel_valid is 1,
// pixel_data, pixel_x, pixel_y and fb_address stay stable. pixel_valid
// never depends combinationally on pixel_ready. Outside OUTPUT,
// pixel_ready is ignored.

module lcd_scanout #(
    parameter int WIDTH  = 96,
    parameter int HEIGHT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [5:0]  start_line,
    input  logic        row_order,
    input  logic        display_enabled,
    input  logic        all_pixels_on,
    input  logic        invert_pixels,
    output logic [10:0] fb_address,
    input  logic [7:0]  fb_data,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        pixel_data,
    output logic [6:0]  pixel_x,
    output logic [5:0]  pixel_y,
    output logic        busy,
    output logic        frame_done
);

    // Last column and last row of the visible window.
    localparam logic [6:0]  X_LAST      = 7'(WIDTH - 1);
    localparam logic [5:0]  Y_LAST      = 6'(HEIGHT - 1);
    // The controller RAM always has 64 lines. Bottom-to-top mirroring is
    // done over the full RAM height, not over the visible height.
    localparam logic [5:0]  LINE_MAX    = 6'd63;
    // Bytes per page in the controller RAM. The RAM is wider than the
    // visible window.
    localparam logic [10:0] PAGE_STRIDE = 11'd132;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t      state_q, state_d;

    // Raster position of the pixel that is currently in flight.
    logic [6:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;

    // Configuration captured at frame_start. It stays frozen for the rest
    // of the frame.
    logic [5:0]  start_line_q, start_line_d;
    logic        row_order_q, row_order_d;
    logic        display_en_q, display_en_d;
    logic        all_on_q, all_on_d;
    logic        invert_q, invert_d;

    // Bit of the fetched byte that belongs to the current line.
    logic [2:0]  bit_sel_q, bit_sel_d;

    // Registered outputs.
    logic [10:0] fb_address_q, fb_address_d;
    logic        pixel_data_q, pixel_data_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    // Line mapping for the position being entered, and its RAM address.
    logic [5:0]  row_d;
    logic [5:0]  line_d;
    logic [2:0]  page_d;
    logic [10:0] addr_calc;

    // Pixel value derived from the byte returned during WAIT.
    logic        fb_bit;
    logic        pixel_value;

    // Pixel value: blanking wins over force-on, and force-on wins over invert.
    always_comb begin
        fb_bit      = fb_data[bit_sel_q];
        pixel_value = 1'b0;
        if (!display_en_q) begin
            pixel_value = 1'b0;
        end else if (all_on_q) begin
            pixel_value = 1'b1;
        end else begin
            pixel_value = fb_bit ^ invert_q;
        end
    end

    // Next-state logic: frame sequencing, raster counters and config latch.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        start_line_d = start_line_q;
        row_order_d  = row_order_q;
        display_en_d = display_en_q;
        all_on_d     = all_on_q;
        invert_d     = invert_q;
        pixel_data_d = pixel_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    start_line_d = start_line;
                    row_order_d  = row_order;
                    display_en_d = display_enabled;
                    all_on_d     = all_pixels_on;
                    invert_d     = invert_pixels;
                    x_d          = '0;
                    y_d          = '0;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // The address is already on the bus. The RAM captures it on this edge.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is valid during this cycle. Capture the pixel.
                pixel_data_d = pixel_value;
                state_d      = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (pixel_ready) begin
                    if (x_q < X_LAST) begin
                        x_d     = x_q + 7'd1;
                        state_d = ST_FETCH;
                    end else if (y_q < Y_LAST) begin
                        x_d     = '0;
                        y_d     = y_q + 6'd1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // A frame_start pulse that arrives here is dropped on purpose.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Map the next raster position to a RAM line, page and byte address.
    always_comb begin
        row_d     = row_order_d ? (LINE_MAX - y_d) : y_d;
        line_d    = row_d + start_line_d;
        page_d    = line_d[5:3];
        addr_calc = ({8'd0, page_d} * PAGE_STRIDE) + {4'd0, x_d};
    end

    // Output register inputs. The address is loaded on entry to FETCH and
    // held at all other times.
    always_comb begin
        fb_address_d  = fb_address_q;
        bit_sel_d     = bit_sel_q;
        if (state_d == ST_FETCH) begin
            fb_address_d = addr_calc;
            bit_sel_d    = line_d[2:0];
        end
        pixel_valid_d = (state_d == ST_OUTPUT);
        busy_d        = (state_d != ST_IDLE);
        frame_done_d  = (state_d == ST_DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= '0;
            y_q           <= '0;
            start_line_q  <= '0;
            row_order_q   <= 1'b0;
            display_en_q  <= 1'b0;
            all_on_q      <= 1'b0;
            invert_q      <= 1'b0;
            bit_sel_q     <= '0;
            fb_address_q  <= '0;
            pixel_data_q  <= 1'b0;
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            start_line_q  <= start_line_d;
            row_order_q   <= row_order_d;
            display_en_q  <= display_en_d;
            all_on_q      <= all_on_d;
            invert_q      <= invert_d;
            bit_sel_q     <= bit_sel_d;
            fb_address_q  <= fb_address_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign fb_address  = fb_address_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_data  = pixel_data_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Self-checking bench for lcd_scanout. It runs a table of frame scenarios
// against a synchronous-read framebuffer model, with scoreboarded pixels,
// a stall sequence, mid-frame perturbation and mid-frame reset.

module tb_lcd_scanout;

    localparam int W      = 96;
    localparam int H      = 64;
    localparam int N      = W * H;
    localparam int MEM_SZ = 1056;

    logic        clk             = 1'b0;
    logic        reset_n         = 1'b0;
    logic        frame_start     = 1'b0;
    logic [5:0]  start_line      = 6'd0;
    logic        row_order       = 1'b0;
    logic        display_enabled = 1'b0;
    logic        all_pixels_on   = 1'b0;
    logic        invert_pixels   = 1'b0;
    logic        pixel_ready     = 1'b0;
    logic [10:0] fb_address;
    logic [7:0]  fb_data;
    logic        pixel_valid;
    logic        pixel_data;
    logic [6:0]  pixel_x;
    logic [5:0]  pixel_y;
    logic        busy;
    logic        frame_done;

    lcd_scanout #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .frame_start     (frame_start),
        .start_line      (start_line),
        .row_order       (row_order),
        .display_enabled (display_enabled),
        .all_pixels_on   (all_pixels_on),
        .invert_pixels   (invert_pixels),
        .fb_address      (fb_address),
        .fb_data         (fb_data),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready),
        .pixel_data      (pixel_data),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    // Clock and the synchronous-read framebuffer.
    always #5 clk = ~clk;

    logic [7:0] mem [MEM_SZ];
    always @(posedge clk) fb_data <= mem[fb_address];

    typedef struct {
        int         fill_mode;  // 0 = constant fill, 1 = random
        logic [7:0] fill;
        logic       marker;     // page0/col5 = 0x01
        logic [5:0] sl;
        logic       ro;
        logic       de;
        logic       ao;
        logic       inv;
        int         n_pix;      // N = full frame, else abort by reset at this pixel
        logic       perturb;
        logic       stall;
        int         exp_ones;   // -1 = not checked
        int         one_x;      // -1 = not checked
        int         one_y;
    } scen_t;

    scen_t scen [8];

    int total = 0;
    int bad   = 0;
    logic [24:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference pixel: {address, x, y, value}.
    function automatic logic [24:0] model(input scen_t s, input int x, input int y);
        logic [5:0]  r;
        logic [5:0]  line;
        logic [10:0] addr;
        logic [7:0]  byte_v;
        logic        b;
        logic        p;
        r      = s.ro ? 6'(63 - y) : 6'(y);
        line   = r + s.sl;
        addr   = 11'(int'(line[5:3]) * 132 + x);
        byte_v = mem[addr];
        b      = byte_v[line[2:0]];
        if (!s.de)     p = 1'b0;
        else if (s.ao) p = 1'b1;
        else           p = b ^ s.inv;
        return {addr, 7'(x), 6'(y), p};
    endfunction

    task automatic fill_mem(input scen_t s);
        for (int i = 0; i < MEM_SZ; i++)
            mem[i] = (s.fill_mode == 1) ? 8'($urandom_range(0, 255)) : s.fill;
        if (s.marker) mem[5] = 8'h01;
    endtask

    task automatic run_scenario(input int idx);
        scen_t       s;
        int          cyc;
        int          acc;
        int          ones;
        int          lx;
        int          ly;
        bit          fin;
        bit          stalled;
        bit          first_seen;
        logic [24:0] e;
        logic [25:0] snap;
        s = scen[idx];
        fill_mem(s);
        exp_q.delete();
        for (int k = 0; k < s.n_pix; k++) exp_q.push_back(model(s, k % W, k / W));
        @(negedge clk);
        start_line      = s.sl;
        row_order       = s.ro;
        display_enabled = s.de;
        all_pixels_on   = s.ao;
        invert_pixels   = s.inv;
        pixel_ready     = 1'b1;
        frame_start     = 1'b1;
        cyc = 0; acc = 0; ones = 0; lx = -1; ly = -1;
        fin = 1'b0; stalled = 1'b0; first_seen = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            frame_start = 1'b0;
            if (cyc == 1) check("busy_after_start", 32'(busy), 32'd1);
            if (s.perturb && (cyc == 300 || cyc == 9001)) begin
                frame_start     = 1'b1;
                start_line      = ~s.sl;
                row_order       = ~s.ro;
                display_enabled = ~s.de;
                all_pixels_on   = 1'b1;
                invert_pixels   = ~s.inv;
            end
            if (cyc > 3 * N + 20) begin
                check("frame_timeout", 32'(cyc), 32'(3 * N + 1));
                fin = 1'b1;
            end else if (frame_done) begin
                check("frame_done_cycle", 32'(cyc), 32'(3 * N + 1));
                check("pixels_before_done", 32'(acc), 32'(s.n_pix));
                // frame_start during DONE must be dropped.
                frame_start = 1'b1;
                for (int t = 0; t < 5; t++) begin
                    @(negedge clk);
                    frame_start = 1'b0;
                    check("idle_after_done", 32'(busy), 32'd0);
                    check("single_frame_done", 32'(frame_done), 32'd0);
                end
                fin = 1'b1;
            end else if (pixel_valid) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    check("first_valid_latency", 32'(cyc), 32'd3);
                end
                if (s.n_pix < N && acc == s.n_pix) begin
                    check("abort_position", 32'({pixel_x, pixel_y}),
                          32'({7'(s.n_pix % W), 6'(s.n_pix / W)}));
                    reset_n = 1'b0;
                    #1;
                    check("abort_busy", 32'(busy), 32'd0);
                    check("abort_valid", 32'(pixel_valid), 32'd0);
                    check("abort_xy", 32'({pixel_x, pixel_y}), 32'd0);
                    @(negedge clk);
                    reset_n = 1'b1;
                    for (int t = 0; t < 20; t++) begin
                        @(negedge clk);
                        check("no_done_after_abort", 32'({busy, frame_done}), 32'd0);
                    end
                    fin = 1'b1;
                end else begin
                    if (s.stall && !stalled) begin
                        snap = {pixel_valid, fb_address, pixel_x, pixel_y, pixel_data};
                        pixel_ready = 1'b0;
                        for (int t = 0; t < 10; t++) begin
                            @(negedge clk);
                            cyc++;
                            check("stall_hold", 32'({pixel_valid, fb_address, pixel_x, pixel_y, pixel_data}),
                                  32'(snap));
                        end
                        pixel_ready = 1'b1;
                        stalled     = 1'b1;
                    end
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_pixel: got x=%0d y=%0d expected no pixel", pixel_x, pixel_y);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", 32'({fb_address, pixel_x, pixel_y, pixel_data}), 32'(e));
                    end
                    if (pixel_data) begin
                        ones++;
                        lx = int'(pixel_x);
                        ly = int'(pixel_y);
                    end
                    acc++;
                end
            end
        end
        if (s.exp_ones >= 0) check("ones_count", 32'(ones), 32'(s.exp_ones));
        if (s.one_x >= 0) check("one_position", 32'(lx * 64 + ly), 32'(s.one_x * 64 + s.one_y));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        start_line = 6'd0; row_order = 1'b0; display_enabled = 1'b0;
        all_pixels_on = 1'b0; invert_pixels = 1'b0;
    endtask

    initial begin
        //           mode fill   mrk  sl     ro    de    ao    inv   n     pert  stall ones x   y
        scen[0] = '{0, 8'h00, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, N,    1'b0, 1'b0, N,  -1, -1};
        scen[1] = '{0, 8'h00, 1'b1, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, N,    1'b1, 1'b0, 1,   5, 63};
        scen[2] = '{0, 8'h00, 1'b1, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1960, 1'b0, 1'b0, 1,   5,  0};
        scen[3] = '{0, 8'h00, 1'b1, 6'd63, 1'b0, 1'b1, 1'b0, 1'b0, 300,  1'b0, 1'b1, 1,   5,  1};
        scen[4] = '{0, 8'hFF, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 300,  1'b0, 1'b0, 0,  -1, -1};
        scen[5] = '{0, 8'hFF, 1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1, 300,  1'b0, 1'b0, 300, -1, -1};
        scen[6] = '{1, 8'h00, 1'b0, 6'd21, 1'b1, 1'b1, 1'b0, 1'b0, 400,  1'b0, 1'b0, -1, -1, -1};
        scen[7] = '{1, 8'h00, 1'b0, 6'd45, 1'b0, 1'b1, 1'b0, 1'b1, 400,  1'b0, 1'b0, -1, -1, -1};

        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'h00;

        // Reset state, with frame_start asserted while reset is held.
        frame_start = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_fb_address", 32'(fb_address), 32'd0);
        check("reset_pixel_valid", 32'(pixel_valid), 32'd0);
        check("reset_pixel_data", 32'(pixel_data), 32'd0);
        check("reset_pixel_xy", 32'({pixel_x, pixel_y}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        frame_start = 1'b0;
        reset_n     = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 32'({busy, pixel_valid, frame_done}), 32'd0);

        for (int i = 0; i < 8; i++) run_scenario(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_scanout.md
LCD_SCANOUT -- requirements
Module: lcd_scanout

Interface
REQ-001 SHALL have the following ports (clock and reset first):
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- frame_start  input  1  one-cycle request to scan one frame
- start_line  input  6  first framebuffer line displayed (wrap-around offset)
- row_order  input  1  1 = rows displayed bottom-to-top
- display_enabled  input  1  0 = blank output
- all_pixels_on  input  1  force every pixel to 1
- invert_pixels  input  1  invert pixel data
- fb_address  output  11  framebuffer byte address, page*132 + column
- fb_data  input  8  framebuffer byte; valid exactly 1 cycle after fb_address
- pixel_valid  output  1  pixel_data/x/y valid
- pixel_ready  input  1  sink accepts pixel
- pixel_data  output  1  pixel value, 1 = dark
- pixel_x  output  7  column 0..95
- pixel_y  output  6  row 0..63
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after last pixel accepted
REQ-002 SHALL have parameters: WIDTH, default 96, displayed columns; HEIGHT, default 64, displayed rows.

Function
REQ-003 SHALL implement states IDLE, FETCH, WAIT, OUTPUT, DONE.
REQ-004 IDLE: frame_start=1 SHALL latch start_line, row_order, display_enabled, all_pixels_on and invert_pixels, clear x,y to 0, and go to FETCH; busy SHALL be 1 in every state except IDLE.
REQ-005 Config input changes after the latch SHALL NOT affect the frame in progress.
REQ-006 frame_start while not IDLE SHALL be ignored, with no restart or queuing.
REQ-007 Line mapping: r = row_order ? 63-y : y; line = (r + start_line) mod 64 (6-bit wrap); page = line[5:3]; bit = line[2:0].
REQ-008 FETCH: fb_address SHALL be page*132 + x, computed 11 bits wide; go to WAIT.
REQ-009 WAIT: fb_data is sampled on this cycle's clock edge; go to OUTPUT.
REQ-010 Pixel computation:
- b = fb_data[bit]
- pixel_data = !display_enabled ? 0 : all_pixels_on ? 1 : b ^ invert_pixels
- all_pixels_on overrides invert_pixels
REQ-011 OUTPUT: pixel_valid SHALL be 1, and pixel_data, pixel_x and pixel_y SHALL hold stable until pixel_ready=1.
REQ-012 Pixel acceptance SHALL occur on the cycle with pixel_valid=1 and pixel_ready=1. On acceptance:
- if x<WIDTH-1: x++ and go to FETCH;
- else if y<HEIGHT-1: x=0, y++ and go to FETCH;
- else go to DONE.
REQ-013 DONE: frame_done=1 for exactly one cycle, then IDLE; frame_start in DONE SHALL be ignored.
REQ-014 Latency: first pixel_valid SHALL assert 3 cycles after the edge sampling frame_start. With pixel_ready held at 1, each pixel SHALL cost exactly 3 cycles, and one frame SHALL take 3*WIDTH*HEIGHT + 1 cycles from frame_start to frame_done.
REQ-015 pixel_valid SHALL be 0 in IDLE, FETCH, WAIT and DONE; pixel_ready outside OUTPUT SHALL be ignored.
REQ-016 fb_address SHALL hold its last value outside FETCH; there is no write path to the framebuffer.

Reset
REQ-017 On reset_n=0, asynchronously:
- state = IDLE, all counters and latched config = 0
- fb_address=0, pixel_valid=0, pixel_data=0, pixel_x=0, pixel_y=0, busy=0, frame_done=0
REQ-018 Reset asserted mid-frame SHALL abort the frame with no frame_done; the block SHALL then wait for a new frame_start.

Verification
REQ-019 Framebuffer all 0x00, invert_pixels=1, pixel_ready=1, frame_start -> 6144 pixels all 1, x/y in raster order, frame_done exactly 18433 cycles after frame_start.
REQ-020 Byte page0/col5 = 0x01, start_line=0 -> only pixel (5,0)=1; start_line=63 -> only (5,1)=1 (wrap); row_order=1, start_line=0 -> only (5,63)=1.
REQ-021 pixel_ready held 0 for 10 cycles on pixel (0,0) -> pixel_valid and outputs stable all 10 cycles; no fb_address change; the next pixel is (1,0).
REQ-022 Config changes and a second frame_start pulse mid-frame -> output unchanged versus the unperturbed run; exactly one frame_done.
REQ-023 display_enabled=0 with all_pixels_on=1 -> all pixels 0; display_enabled=1 with all_pixels_on=1 and invert_pixels=1 -> all pixels 1.
REQ-024 reset_n pulsed low at pixel (40,20) -> busy=0 and pixel_valid=0 immediately; no frame_done; a new frame_start restarts at (0,0).
